// File: rtl/enc3b4b_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : enc3b4b_lanes
//  Purpose  : Multi-lane 3B/4B sub-block encoder (fghj, A7 select, running
//             disparity, control-code error) behind a 2-entry skid buffer.
//  Option   : ENC3B4B_A7_CNT_EN adds the saturating a7_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module enc3b4b_lanes #(
   parameter int LANES     = 4,
   parameter int ERR_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3*LANES-1:0]     data_in,
   input  logic [LANES-1:0]       k_in,
   input  logic [LANES-1:0]       k28_in,
   input  logic [LANES-1:0]       rd6_in,
   input  logic [2*LANES-1:0]     ei_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*LANES-1:0]     code_out,
   output logic [LANES-1:0]       rd4_out,
   output logic [LANES-1:0]       kerr_out,
   output logic [ERR_CNT_W-1:0]   err_cnt
`ifdef ENC3B4B_A7_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0]   a7_cnt
`endif
);

   localparam int c_EW = 6 * LANES;

   function automatic logic is_a7(input logic [2:0] x, input logic k,
                                  input logic rd6, input logic [1:0] ei);
      return (x == 3'd7) & ((~rd6 & (ei == 2'b11)) | (rd6 & (ei == 2'b00)) | k);
   endfunction

   // Returns {kerr, rd4, fghj}
   function automatic logic [5:0] enc_lane(input logic [2:0] x, input logic k,
                                           input logic k28, input logic rd6,
                                           input logic [1:0] ei);
      logic       rn;
      logic [3:0] d;
      logic       rd4;
      logic       kerr;
      rn = ~rd6;
      case (x)
         3'd0:    d = rn ? 4'b1011 : 4'b0100;
         3'd1:    d = 4'b1001;
         3'd2:    d = 4'b0101;
         3'd3:    d = rn ? 4'b1100 : 4'b0011;
         3'd4:    d = rn ? 4'b1101 : 4'b0010;
         3'd5:    d = 4'b1010;
         3'd6:    d = 4'b0110;
         default: d = is_a7(x, k, rd6, ei) ? (rn ? 4'b0111 : 4'b1000)
                                           : (rn ? 4'b1110 : 4'b0001);
      endcase
      // Balanced control codes take the polarity of the incoming disparity
      if (k & rn & ((x == 3'd1) | (x == 3'd2) | (x == 3'd5) | (x == 3'd6)))
         d = ~d;
      rd4  = rd6 ^ ((x == 3'd0) | (x == 3'd4) | (x == 3'd7));
      kerr = k & ~k28 & (x != 3'd7);
      return {kerr, rd4, d};
   endfunction

   logic [4*LANES-1:0] w_code;
   logic [LANES-1:0]   w_rd4;
   logic [LANES-1:0]   w_kerr;
   logic [5:0]         w_lane [LANES];

   always_comb begin
      w_code = '0;
      w_rd4  = '0;
      w_kerr = '0;
      for (int i = 0; i < LANES; i++) begin
         w_lane[i] = enc_lane(data_in[3*i +: 3], k_in[i], k28_in[i],
                              rd6_in[i], ei_in[2*i +: 2]);
         w_code[4*i +: 4] = w_lane[i][3:0];
         w_rd4[i]         = w_lane[i][4];
         w_kerr[i]        = w_lane[i][5];
      end
   end

   logic [c_EW-1:0]      r_mem [2];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [1:0]           r_count;
   logic                 r_in_ready;
   logic [ERR_CNT_W-1:0] r_err_cnt;
   logic                 w_push;
   logic                 w_pop;
   logic [1:0]           w_count_nxt;

   assign w_push = in_valid & r_in_ready;
   assign w_pop  = (r_count != 2'd0) & out_ready;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push & ~w_pop)
         w_count_nxt = r_count + 2'd1;
      else if (~w_push & w_pop)
         w_count_nxt = r_count - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int e = 0; e < 2; e++)
            r_mem[e] <= '0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_in_ready <= 1'b1;
         r_err_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {w_kerr, w_rd4, w_code};
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         r_count    <= w_count_nxt;
         r_in_ready <= (w_count_nxt != 2'd2);
         if (w_push && (|w_kerr) && (r_err_cnt != {ERR_CNT_W{1'b1}}))
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_count != 2'd0);
   assign {kerr_out, rd4_out, code_out} = r_mem[r_rd_ptr];
   assign err_cnt   = r_err_cnt;

`ifdef ENC3B4B_A7_CNT_EN
   localparam int c_SW = ERR_CNT_W + 5;

   logic [3:0]           w_a7_num;
   logic [c_SW-1:0]      w_a7_sum;
   logic [ERR_CNT_W-1:0] r_a7_cnt;

   always_comb begin
      w_a7_num = '0;
      for (int i = 0; i < LANES; i++)
         w_a7_num = w_a7_num + {3'b000, is_a7(data_in[3*i +: 3], k_in[i],
                                              rd6_in[i], ei_in[2*i +: 2])};
      w_a7_sum = c_SW'(r_a7_cnt) + c_SW'(w_a7_num);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_a7_cnt <= '0;
      else if (w_push) begin
         if (w_a7_sum[c_SW-1:ERR_CNT_W] != '0)
            r_a7_cnt <= {ERR_CNT_W{1'b1}};
         else
            r_a7_cnt <= w_a7_sum[ERR_CNT_W-1:0];
      end
   end

   assign a7_cnt = r_a7_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_enc3b4b_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enc3b4b_lanes
//  Purpose  : Directed self-checking bench for enc3b4b_lanes (4 lanes); a
//             second instance with a 2-bit error counter shows saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_enc3b4b_lanes;

   localparam int LANES = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [11:0] data_in;
   logic [3:0]  k_in;
   logic [3:0]  k28_in;
   logic [3:0]  rd6_in;
   logic [7:0]  ei_in;

   logic        in_ready,  in_ready2;
   logic        out_valid, out_valid2;
   logic [15:0] code_out,  code_out2;
   logic [3:0]  rd4_out,   rd4_out2;
   logic [3:0]  kerr_out,  kerr_out2;
   logic [15:0] err_cnt;
   logic [1:0]  err_cnt2;
`ifdef ENC3B4B_A7_CNT_EN
   logic [15:0] a7_cnt;
   logic [1:0]  a7_cnt2;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   enc3b4b_lanes #(.LANES(LANES), .ERR_CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .k_in(k_in), .k28_in(k28_in), .rd6_in(rd6_in),
      .ei_in(ei_in), .out_valid(out_valid), .out_ready(out_ready),
      .code_out(code_out), .rd4_out(rd4_out), .kerr_out(kerr_out),
      .err_cnt(err_cnt)
`ifdef ENC3B4B_A7_CNT_EN
      , .a7_cnt(a7_cnt)
`endif
   );

   enc3b4b_lanes #(.LANES(LANES), .ERR_CNT_W(2)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .data_in(data_in), .k_in(k_in), .k28_in(k28_in), .rd6_in(rd6_in),
      .ei_in(ei_in), .out_valid(out_valid2), .out_ready(out_ready),
      .code_out(code_out2), .rd4_out(rd4_out2), .kerr_out(kerr_out2),
      .err_cnt(err_cnt2)
`ifdef ENC3B4B_A7_CNT_EN
      , .a7_cnt(a7_cnt2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_lane(input int i, input logic [2:0] x, input logic k,
                           input logic k28, input logic rd6, input logic [1:0] ei);
      data_in[3*i +: 3] = x;
      k_in[i]           = k;
      k28_in[i]         = k28;
      rd6_in[i]         = rd6;
      ei_in[2*i +: 2]   = ei;
   endtask

   task automatic set_all(input logic [2:0] x, input logic k, input logic k28,
                          input logic rd6, input logic [1:0] ei);
      for (int i = 0; i < LANES; i++)
         set_lane(i, x, k, k28, rd6, ei);
   endtask

   // Drive one beat for one clock; outputs are then checked on this negedge
   task automatic send;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_all(3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_code",      code_out,  0);
      check("rst_rd4",       rd4_out,   0);
      check("rst_kerr",      kerr_out,  0);
      check("rst_err_cnt",   err_cnt,   0);
      check("rst_in_ready",  in_ready,  1);

      // D.x.0 with positive incoming disparity
      set_all(3'd0, 1'b0, 1'b0, 1'b1, 2'b00);
      send();
      check("x0_valid", out_valid, 1);
      check("x0_code",  code_out,  16'h4444);
      check("x0_rd4",   rd4_out,   4'b0000);
      check("x0_kerr",  kerr_out,  4'b0000);

      // x.7: A7 by ei=11/rn, primary by ei=10, primary rd6=1 ei=11, A7 rd6=1 ei=00
      set_lane(0, 3'd7, 1'b0, 1'b0, 1'b0, 2'b11);
      set_lane(1, 3'd7, 1'b0, 1'b0, 1'b0, 2'b10);
      set_lane(2, 3'd7, 1'b0, 1'b0, 1'b1, 2'b11);
      set_lane(3, 3'd7, 1'b0, 1'b0, 1'b1, 2'b00);
      send();
      check("x7_code", code_out, 16'h81E7);
      check("x7_rd4",  rd4_out,  4'b0011);
      check("x7_kerr", kerr_out, 4'b0000);
`ifdef ENC3B4B_A7_CNT_EN
      check("x7_a7_cnt", a7_cnt, 2);
`endif

      // K28.5 on both disparities
      set_lane(0, 3'd5, 1'b1, 1'b1, 1'b1, 2'b00);
      set_lane(1, 3'd5, 1'b1, 1'b1, 1'b1, 2'b00);
      set_lane(2, 3'd5, 1'b1, 1'b1, 1'b0, 2'b00);
      set_lane(3, 3'd5, 1'b1, 1'b1, 1'b0, 2'b00);
      send();
      check("k285_code", code_out, 16'h55AA);
      check("k285_rd4",  rd4_out,  4'b0011);
      check("k285_kerr", kerr_out, 4'b0000);

      // Illegal control code on lane 2
      set_all(3'd0, 1'b0, 1'b0, 1'b1, 2'b00);
      set_lane(2, 3'd3, 1'b1, 1'b0, 1'b1, 2'b00);
      send();
      check("kerr_code", code_out, 16'h4344);
      check("kerr_rd4",  rd4_out,  4'b0100);
      check("kerr_flag", kerr_out, 4'b0100);
      check("kerr_cnt1", err_cnt,  1);
      check("kerr_sat1", err_cnt2, 1);
      repeat (5) send();
      check("kerr_cnt6", err_cnt,  6);
      check("kerr_sat",  err_cnt2, 3);

      @(negedge clk);
      check("drain_valid", out_valid, 0);

      // Stall: three beats against out_ready=0
      out_ready = 1'b0;
      set_all(3'd2, 1'b0, 1'b0, 1'b0, 2'b00);
      in_valid = 1'b1;
      @(negedge clk);
      check("st1_ready", in_ready,  1);
      check("st1_valid", out_valid, 1);
      check("st1_code",  code_out,  16'h5555);
      set_all(3'd6, 1'b0, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
      check("st2_ready", in_ready, 0);
      check("st2_code",  code_out, 16'h5555);
      set_all(3'd4, 1'b0, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
      check("st3_ready", in_ready,  0);
      check("st3_valid", out_valid, 1);
      check("st3_code",  code_out,  16'h5555);
      out_ready = 1'b1;
      @(negedge clk);
      check("rel1_code",  code_out, 16'h6666);
      check("rel1_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("rel2_code", code_out, 16'hDDDD);
      check("rel2_rd4",  rd4_out,  4'b1111);
      @(negedge clk);
      check("rel3_valid", out_valid, 0);
      check("stall_err",  err_cnt,   6);

      // Reset with two beats buffered
      out_ready = 1'b0;
      set_all(3'd2, 1'b0, 1'b0, 1'b0, 2'b00);
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      check("full_ready", in_ready, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_valid", out_valid, 0);
      check("mrst_code",  code_out,  0);
      check("mrst_err",   err_cnt,   0);
      check("mrst_err2",  err_cnt2,  0);
      check("mrst_ready", in_ready,  1);
      out_ready = 1'b1;

      // Three A7 lanes (two forced by k) and a complemented K.x.1
      set_lane(0, 3'd7, 1'b1, 1'b1, 1'b1, 2'b01);
      set_lane(1, 3'd7, 1'b1, 1'b0, 1'b0, 2'b01);
      set_lane(2, 3'd7, 1'b0, 1'b0, 1'b1, 2'b00);
      set_lane(3, 3'd1, 1'b1, 1'b1, 1'b0, 2'b00);
      send();
      check("a7_code", code_out, 16'h6878);
      check("a7_rd4",  rd4_out,  4'b0010);
      check("a7_kerr", kerr_out, 4'b0000);
`ifdef ENC3B4B_A7_CNT_EN
      check("a7_cnt3", a7_cnt, 3);
`endif

      // Negative-disparity codes for x=0/3, x=4 positive, illegal K.x.6
      set_lane(0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      set_lane(1, 3'd3, 1'b0, 1'b0, 1'b0, 2'b00);
      set_lane(2, 3'd4, 1'b0, 1'b0, 1'b1, 2'b00);
      set_lane(3, 3'd6, 1'b1, 1'b0, 1'b0, 2'b00);
      send();
      check("mix_code", code_out, 16'h92CB);
      check("mix_rd4",  rd4_out,  4'b0001);
      check("mix_kerr", kerr_out, 4'b1000);
      check("mix_err",  err_cnt,  1);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
